sent_tx_pulse_gen: RTL and testbench

SENT_TX_PULSE_GEN -- requirements
Module: sent_tx_pulse_gen

---
 rtl/sent_pkg.sv | 54 +++++
 rtl/sent_tick_gen.sv | 35 +++
 rtl/sent_tx_pulse_gen.sv | 184 ++++++++++++++++++
 tb/tb_sent_tx_pulse_gen.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sent_pkg.sv
// -----------------------------------------------------------------------------
// sent_pkg
// Shared definitions for the SENT transmit pulse generator:
//   - sent_state_e : frame sequencer states
//   - SYNC_TICKS, NIB_BASE, PAUSE_MIN, PAUSE_MAX : pulse length constants (ticks)
//   - CRC4_TABLE / crc4() : SENT CRC over the three data nibbles
//   - pause_clamp() : limits the requested pause length to the legal window
// -----------------------------------------------------------------------------
package sent_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_STATUS,
        ST_DATA,
        ST_CRC,
        ST_PAUSE
    } sent_state_e;

    localparam logic [9:0] SYNC_TICKS = 10'd56;
    localparam logic [9:0] NIB_BASE   = 10'd12;
    localparam logic [9:0] PAUSE_MIN  = 10'd12;
    localparam logic [9:0] PAUSE_MAX  = 10'd768;

    // Packed so that CRC4_TABLE[i] is entry i; listed from entry 15 down to 0.
    localparam logic [15:0][3:0] CRC4_TABLE = {
        4'd5, 4'd8, 4'd2, 4'd15, 4'd11, 4'd6, 4'd12, 4'd1,
        4'd4, 4'd9, 4'd3, 4'd14, 4'd10, 4'd7, 4'd13, 4'd0
    };

    // Seed 5, one table step per nibble (MSN first), then one augmentation step.
    function automatic logic [3:0] crc4(input logic [11:0] word);
        logic [3:0] c;
        c = 4'h5;
        c = word[11:8] ^ CRC4_TABLE[c];
        c = word[7:4]  ^ CRC4_TABLE[c];
        c = word[3:0]  ^ CRC4_TABLE[c];
        c = CRC4_TABLE[c];
        return c;
    endfunction

    function automatic logic [9:0] pause_clamp(input logic [9:0] ticks);
        logic [9:0] r;
        if (ticks < PAUSE_MIN) begin
            r = PAUSE_MIN;
        end else if (ticks > PAUSE_MAX) begin
            r = PAUSE_MAX;
        end else begin
            r = ticks;
        end
        return r;
    endfunction

endpackage

// File: rtl/sent_tick_gen.sv
// -----------------------------------------------------------------------------
// sent_tick_gen
// Prescaler producing one SENT tick every TICK_DIV clock cycles.
//   clk_tx  : clock
//   clr_i   : synchronous clear; counter restarts so the first tick lands
//             TICK_DIV cycles after clr_i is released
//   tick_o  : one-cycle pulse on the last cycle of each tick period
// -----------------------------------------------------------------------------
module sent_tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk_tx,
    input  logic clr_i,
    output logic tick_o
);

    localparam logic [7:0] LAST = 8'(TICK_DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (clr_i || (cnt_q == LAST)) begin
            cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk_tx) begin
        cnt_q <= cnt_d;
    end

    assign tick_o = (cnt_q == LAST) && !clr_i;

endmodule

// File: rtl/sent_tx_pulse_gen.sv
// -----------------------------------------------------------------------------
// sent_tx_pulse_gen
// SENT transmitter: pops a 12-bit word from a first-word-fall-through FIFO and
// sends SYNC, STATUS, 3 DATA nibbles, CRC and an optional PAUSE pulse.
// Every pulse is LOW_TICKS ticks low followed by high for the rest of its length.
//   clk_tx, reset_tx      : clock, synchronous active-high reset
//   tx_en                 : transmit enable (checked only at frame boundaries)
//   status_nib            : status nibble, sampled at the pop
//   pause_en, pause_ticks : optional pause pulse and its length, sampled at the pop
//   fifo_empty/fifo_rdata : FIFO flag and head word
//   fifo_rd_en            : pops the FIFO head in the same cycle
//   sent_out              : registered SENT line, idle high
//   busy                  : frame in progress
//   frame_done            : one-cycle pulse on the last cycle of a frame
// -----------------------------------------------------------------------------
module sent_tx_pulse_gen
    import sent_pkg::*;
#(
    parameter int TICK_DIV  = 4,
    parameter int LOW_TICKS = 5
) (
    input  logic        clk_tx,
    input  logic        reset_tx,
    input  logic        tx_en,
    input  logic [3:0]  status_nib,
    input  logic        pause_en,
    input  logic [9:0]  pause_ticks,
    input  logic        fifo_empty,
    input  logic [11:0] fifo_rdata,
    output logic        fifo_rd_en,
    output logic        sent_out,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [9:0] LOW_LEN = 10'(LOW_TICKS);

    sent_state_e state_q, state_d;
    logic [9:0]  tcnt_q, tcnt_d;
    logic [1:0]  nib_q, nib_d;
    logic        sent_q, sent_d;

    logic [11:0] word_q;
    logic [3:0]  status_q;
    logic        pause_en_q;
    logic [9:0]  pause_len_q;

    logic        tick;
    logic        tick_clr;
    logic        pop_ok;
    logic        load;
    logic        last;
    logic        pulse_end;
    logic [3:0]  cur_nib;
    logic [9:0]  pulse_len;

    // Held in clear while idle so the first tick of a frame is exactly
    // TICK_DIV cycles after the pop; between pulses it wraps on its own.
    assign tick_clr = reset_tx || (state_q == ST_IDLE);

    sent_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk_tx (clk_tx),
        .clr_i  (tick_clr),
        .tick_o (tick)
    );

    assign pop_ok = tx_en && !fifo_empty && !reset_tx;

    always_comb begin
        case (nib_q)
            2'd0:    cur_nib = word_q[11:8];
            2'd1:    cur_nib = word_q[7:4];
            default: cur_nib = word_q[3:0];
        endcase
    end

    always_comb begin
        case (state_q)
            ST_SYNC:   pulse_len = SYNC_TICKS;
            ST_STATUS: pulse_len = NIB_BASE + {6'd0, status_q};
            ST_DATA:   pulse_len = NIB_BASE + {6'd0, cur_nib};
            ST_CRC:    pulse_len = NIB_BASE + {6'd0, crc4(word_q)};
            ST_PAUSE:  pulse_len = pause_len_q;
            default:   pulse_len = SYNC_TICKS;
        endcase
    end

    assign pulse_end = tick && (state_q != ST_IDLE) && (tcnt_q == (pulse_len - 10'd1));

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        nib_d   = nib_q;
        load    = 1'b0;
        last    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pop_ok) begin
                    load    = 1'b1;
                    state_d = ST_SYNC;
                    tcnt_d  = 10'd0;
                    nib_d   = 2'd0;
                end
            end
            default: begin
                if (pulse_end) begin
                    tcnt_d = 10'd0;
                    case (state_q)
                        ST_SYNC: state_d = ST_STATUS;
                        ST_STATUS: begin
                            state_d = ST_DATA;
                            nib_d   = 2'd0;
                        end
                        ST_DATA: begin
                            if (nib_q == 2'd2) begin
                                state_d = ST_CRC;
                            end else begin
                                nib_d = nib_q + 2'd1;
                            end
                        end
                        ST_CRC: begin
                            if (pause_en_q) begin
                                state_d = ST_PAUSE;
                            end else begin
                                last = 1'b1;
                            end
                        end
                        default: last = 1'b1;
                    endcase
                end else if (tick) begin
                    tcnt_d = tcnt_q + 10'd1;
                end

                // End of frame: chain straight into the next one when possible.
                if (last) begin
                    if (pop_ok) begin
                        load    = 1'b1;
                        state_d = ST_SYNC;
                        nib_d   = 2'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase

        // Line level is derived from the next tick position so the register
        // falls on the first cycle of each pulse.
        sent_d = (state_d == ST_IDLE) || (tcnt_d >= LOW_LEN);
    end

    always_ff @(posedge clk_tx) begin
        if (reset_tx) begin
            state_q <= ST_IDLE;
            tcnt_q  <= 10'd0;
            nib_q   <= 2'd0;
            sent_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            nib_q   <= nib_d;
            sent_q  <= sent_d;
        end
    end

    // Frame parameters are captured at the pop and held for the whole frame.
    always_ff @(posedge clk_tx) begin
        if (load) begin
            word_q      <= fifo_rdata;
            status_q    <= status_nib;
            pause_en_q  <= pause_en;
            pause_len_q <= pause_clamp(pause_ticks);
        end
    end

    assign fifo_rd_en = load;
    assign frame_done = last && !reset_tx;
    assign busy       = (state_q != ST_IDLE);
    assign sent_out   = sent_q;

endmodule

// File: tb/tb_sent_tx_pulse_gen.sv
module tb_sent_tx_pulse_gen;

    localparam int TD  = 4;
    localparam int LOW = 5;

    logic        clk_tx = 1'b0;
    logic        reset_tx;
    logic        tx_en;
    logic [3:0]  status_nib;
    logic        pause_en;
    logic [9:0]  pause_ticks;
    logic        fifo_empty;
    logic [11:0] fifo_rdata;
    logic        fifo_rd_en;
    logic        sent_out;
    logic        busy;
    logic        frame_done;

    sent_tx_pulse_gen #(
        .TICK_DIV  (TD),
        .LOW_TICKS (LOW)
    ) dut (
        .clk_tx      (clk_tx),
        .reset_tx    (reset_tx),
        .tx_en       (tx_en),
        .status_nib  (status_nib),
        .pause_en    (pause_en),
        .pause_ticks (pause_ticks),
        .fifo_empty  (fifo_empty),
        .fifo_rdata  (fifo_rdata),
        .fifo_rd_en  (fifo_rd_en),
        .sent_out    (sent_out),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk_tx = ~clk_tx;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // FIFO model (first-word-fall-through)
    logic [11:0] fifo_q[$];
    int pops = 0;

    task automatic fifo_refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_rdata = (fifo_q.size() == 0) ? 12'h000 : fifo_q[0];
    endtask

    task automatic fifo_push(input logic [11:0] w);
        fifo_q.push_back(w);
        fifo_refresh();
    endtask

    // Reference model: expected pulse lengths in cycles, built per frame.
    int exp_q[$];
    int T[16] = '{0, 13, 7, 10, 14, 3, 9, 4, 1, 12, 6, 11, 15, 2, 8, 5};

    task automatic model_frame(input logic [11:0] w, input int st, input logic pe, input int pt);
        int nibs[3];
        int c;
        int p;
        nibs[0] = int'(w[11:8]);
        nibs[1] = int'(w[7:4]);
        nibs[2] = int'(w[3:0]);
        c = 5;
        for (int k = 0; k < 3; k++) c = nibs[k] ^ T[c];
        c = T[c];
        exp_q.push_back(56 * TD);
        exp_q.push_back((12 + st) * TD);
        for (int k = 0; k < 3; k++) exp_q.push_back((12 + nibs[k]) * TD);
        exp_q.push_back((12 + c) * TD);
        if (pe) begin
            p = (pt < 12) ? 12 : ((pt > 768) ? 768 : pt);
            exp_q.push_back(p * TD);
        end
    endtask

    always @(posedge clk_tx) begin
        if (fifo_rd_en === 1'b1) begin
            pops++;
            if (fifo_q.size() == 0) begin
                check_eq("pop_when_empty", 1, 0);
            end else begin
                model_frame(fifo_q[0], int'(status_nib), pause_en, int'(pause_ticks));
            end
            #1;
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            fifo_refresh();
        end
    end

    // Line monitor: measures every pulse and compares with the model queue.
    int  cyc = 0;
    int  done_cnt = 0;
    int  cur_len = 0;
    int  cur_low = 0;
    int  last_pulse_len = 0;
    int  frame_start_cyc = 0;
    int  last_done_cyc = -1000;
    int  frame_gap = 0;
    bit  mon_active = 0;
    bit  prev_sent = 1;

    task automatic take_pulse();
        int e;
        last_pulse_len = cur_len;
        if (exp_q.size() == 0) begin
            check_eq("unexpected_pulse", cur_len, 0);
        end else begin
            e = exp_q.pop_front();
            check_eq("pulse_len", cur_len, e);
            check_eq("pulse_low", cur_low, LOW * TD);
        end
    endtask

    always @(negedge clk_tx) begin
        if (reset_tx === 1'b1) begin
            mon_active = 0;
            prev_sent  = 1;
        end else begin
            if (prev_sent && (sent_out === 1'b0)) begin
                if (mon_active) begin
                    take_pulse();
                end else begin
                    frame_start_cyc = cyc;
                    frame_gap = cyc - last_done_cyc;
                end
                mon_active = 1;
                cur_len = 0;
                cur_low = 0;
            end
            if (mon_active) begin
                cur_len++;
                if (sent_out !== 1'b1) cur_low++;
            end
            if (frame_done === 1'b1) begin
                done_cnt++;
                last_done_cyc = cyc;
                if (mon_active) take_pulse();
                mon_active = 0;
            end
            prev_sent = (sent_out === 1'b1);
        end
        cyc++;
    end

    task automatic wait_frames(input int target, input int budget);
        int k = 0;
        while (done_cnt < target && k < budget) begin
            @(negedge clk_tx);
            k++;
        end
        @(negedge clk_tx);
        check_eq("frame_timeout", int'(done_cnt >= target), 1);
    endtask

    task automatic wait_pops(input int target, input int budget);
        int k = 0;
        while (pops < target && k < budget) begin
            @(negedge clk_tx);
            k++;
        end
        check_eq("pop_timeout", int'(pops >= target), 1);
    endtask

    initial begin
        int d0;
        int p0;
        int nw;

        reset_tx    = 1'b1;
        tx_en       = 1'b1;
        status_nib  = 4'd0;
        pause_en    = 1'b0;
        pause_ticks = 10'd0;
        fifo_refresh();

        // Reset with a pending word and tx_en high: line idle, no pop.
        repeat (3) @(negedge clk_tx);
        fifo_push(12'h001);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_tx);
            check_eq("rst_rd_en", int'(fifo_rd_en), 0);
        end
        check_eq("rst_sent_out", int'(sent_out), 1);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_pops", pops, 0);

        // Word 0x001: 56/12/12/12/13/16 ticks, 484 cycles.
        reset_tx = 1'b0;
        wait_frames(1, 5000);
        repeat (20) @(negedge clk_tx);
        check_eq("f001_frame_cycles", last_done_cyc - frame_start_cyc + 1, 484);
        check_eq("f001_crc_pulse", last_pulse_len, 64);
        check_eq("f001_done_count", done_cnt, 1);
        check_eq("f001_pops", pops, 1);
        check_eq("f001_idle_busy", int'(busy), 0);

        // Word 0x005: CRC 0xA -> 22 ticks.
        d0 = done_cnt;
        fifo_push(12'h005);
        wait_frames(d0 + 1, 5000);
        check_eq("f005_crc_pulse", last_pulse_len, 88);

        // Two queued words: back-to-back frames.
        repeat (10) @(negedge clk_tx);
        d0 = done_cnt;
        p0 = pops;
        fifo_push(12'h001);
        fifo_push(12'h002);
        wait_frames(d0 + 2, 10000);
        check_eq("b2b_pops", pops - p0, 2);
        check_eq("b2b_gap", frame_gap, 1);
        check_eq("b2b_crc_pulse", last_pulse_len, 104);

        // Pause clamping.
        pause_en    = 1'b1;
        pause_ticks = 10'd5;
        d0 = done_cnt;
        fifo_push(12'h001);
        wait_frames(d0 + 1, 5000);
        check_eq("pause_min", last_pulse_len, 12 * TD);
        pause_ticks = 10'd1000;
        fifo_push(12'h001);
        wait_frames(d0 + 2, 6000);
        check_eq("pause_max", last_pulse_len, 768 * TD);
        pause_en = 1'b0;

        // tx_en dropped during STATUS: frame completes, second word stays.
        repeat (5) @(negedge clk_tx);
        d0 = done_cnt;
        p0 = pops;
        fifo_push(12'h3C7);
        fifo_push(12'h8E1);
        wait_pops(p0 + 1, 100);
        repeat (56 * TD + 8) @(negedge clk_tx);
        tx_en = 1'b0;
        wait_frames(d0 + 1, 5000);
        repeat (100) @(negedge clk_tx);
        check_eq("txoff_pops", pops - p0, 1);
        check_eq("txoff_fifo_left", fifo_q.size(), 1);
        check_eq("txoff_sent_out", int'(sent_out), 1);
        check_eq("txoff_busy", int'(busy), 0);
        tx_en = 1'b1;
        wait_frames(d0 + 2, 5000);

        // Reset during DATA: line high next cycle, no pop while held.
        repeat (5) @(negedge clk_tx);
        d0 = done_cnt;
        p0 = pops;
        fifo_push(12'hA5F);
        wait_pops(p0 + 1, 100);
        repeat (68 * TD + 10) @(negedge clk_tx);
        reset_tx = 1'b1;
        exp_q.delete();
        fifo_push(12'h123);
        @(negedge clk_tx);
        check_eq("rstdata_sent_out", int'(sent_out), 1);
        check_eq("rstdata_busy", int'(busy), 0);
        for (int i = 0; i < 4; i++) begin
            check_eq("rstdata_rd_en", int'(fifo_rd_en), 0);
            @(negedge clk_tx);
        end
        check_eq("rstdata_pops", pops - p0, 1);
        check_eq("rstdata_done", done_cnt, d0);
        reset_tx = 1'b0;
        wait_frames(d0 + 1, 5000);

        // Randomized frames; inputs change mid-frame after each pop.
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(1, 20)) @(negedge clk_tx);
            d0 = done_cnt;
            p0 = pops;
            nw = $urandom_range(1, 2);
            status_nib  = 4'($urandom);
            pause_en    = 1'($urandom);
            pause_ticks = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 15))
                                                      : 10'($urandom_range(0, 400));
            for (int j = 0; j < nw; j++) fifo_push(12'($urandom));
            wait_pops(p0 + 1, 100);
            @(negedge clk_tx);
            status_nib  = 4'($urandom);
            pause_en    = 1'($urandom);
            pause_ticks = 10'($urandom_range(0, 400));
            wait_frames(d0 + nw, 5000 * nw);
        end

        repeat (10) @(negedge clk_tx);
        check_eq("end_exp_empty", exp_q.size(), 0);
        check_eq("end_fifo_empty", fifo_q.size(), 0);
        check_eq("end_busy", int'(busy), 0);
        check_eq("end_sent_out", int'(sent_out), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
